// File: rtl/surf_cout_align_sequencer.sv
// COUT lane alignment sequencer: sweeps IDELAY taps, centers on the widest eye, then bitslips to lock.
// Optional SURF_ALIGN_EYE_MAP_EN builds a per-tap pass map register for eye_map_o.
module surf_cout_align_sequencer #(
  parameter logic [31:0] TRAIN_SEQUENCE  = 32'hA55A6996,
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned MIN_EYE         = 4,
  parameter int unsigned MAX_BITSLIP     = 8,
  parameter int unsigned CAPTURE_TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [1:0]  fail_code_o,
  output logic        iserdes_rst_o,
  output logic [5:0]  idelay_value_o,
  output logic        idelay_load_o,
  output logic        iserdes_bitslip_o,
  output logic        capture_o,
  input  logic        capture_valid_i,
  input  logic [31:0] capture_data_i,
  output logic [5:0]  eye_start_o,
  output logic [6:0]  eye_width_o,
  output logic [3:0]  bitslip_count_o,
  output logic [63:0] eye_map_o
);

  typedef enum logic [3:0] {
    StIdle, StSrst, StLoad, StSettle, StCapture, StWait, StEval, StPick,
    StCload, StCsettle, StCcapture, StCwait, StCheck, StSlip, StDone, StFail
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  tap_q, tap_d;
  logic [5:0]  run_start_q, run_start_d, best_start_q, best_start_d;
  logic [6:0]  run_len_q, run_len_d, best_w_q, best_w_d;
  logic        hit_q, hit_d;
  logic        busy_d, done_d, fail_d, srst_d, load_d, slip_d, cap_d;
  logic [1:0]  code_d;
  logic [5:0]  value_d, eye_start_d;
  logic [6:0]  eye_width_d;
  logic [3:0]  slips_d;
  logic [6:0]  new_len, center_sum;
  logic [5:0]  new_start;
  logic [63:0] map_d;

  function automatic logic is_rotation(input logic [31:0] d);
    logic        m;
    logic [31:0] r;
    m = 1'b0;
    r = TRAIN_SEQUENCE;
    for (int i = 0; i < 32; i++) begin
      if (d == r) m = 1'b1;
      r = {r[30:0], r[31]};
    end
    return m;
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tap_d        = tap_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_w_d     = best_w_q;
    hit_d        = hit_q;
    done_d       = done_o;
    fail_d       = fail_o;
    code_d       = fail_code_o;
    value_d      = idelay_value_o;
    eye_start_d  = eye_start_o;
    eye_width_d  = eye_width_o;
    slips_d      = bitslip_count_o;
    map_d        = eye_map_o;
    new_len      = hit_q ? run_len_q + 7'd1 : 7'd0;
    new_start    = (run_len_q == 7'd0) ? tap_q : run_start_q;
    center_sum   = {1'b0, best_start_q} + (best_w_q >> 1);

    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (start_i) begin
          state_d      = StSrst;
          cnt_d        = '0;
          tap_d        = '0;
          run_start_d  = '0;
          run_len_d    = '0;
          best_start_d = '0;
          best_w_d     = '0;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          code_d       = 2'b00;
          eye_start_d  = '0;
          eye_width_d  = '0;
          slips_d      = '0;
          map_d        = '0;
        end
      end
      StSrst: begin
        if (cnt_q == 8'd3) begin
          state_d = StLoad;
          value_d = tap_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StLoad, StCload, StSlip: begin
        state_d = (state_q == StLoad) ? StSettle : StCsettle;
        cnt_d   = '0;
      end
      StSettle, StCsettle: begin
        if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
          state_d = (state_q == StSettle) ? StCapture : StCcapture;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StCapture, StCcapture: begin
        state_d = (state_q == StCapture) ? StWait : StCwait;
        cnt_d   = '0;
      end
      StWait, StCwait: begin
        if (capture_valid_i) begin
          // Scan accepts any rotation; centre check demands exact alignment.
          hit_d   = (state_q == StWait) ? is_rotation(capture_data_i)
                                        : (capture_data_i == TRAIN_SEQUENCE);
          state_d = (state_q == StWait) ? StEval : StCheck;
        end else if (cnt_q == 8'(CAPTURE_TIMEOUT - 1)) begin
          state_d = StFail;
          fail_d  = 1'b1;
          code_d  = 2'b11;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StEval: begin
        run_len_d   = new_len;
        run_start_d = new_start;
        // Strictly-longer replacement keeps the lowest-start eye on ties.
        if (hit_q && new_len > best_w_q) begin
          best_w_d     = new_len;
          best_start_d = new_start;
        end
`ifdef SURF_ALIGN_EYE_MAP_EN
        map_d[tap_q] = hit_q;
`endif
        if (tap_q == 6'd63) begin
          state_d = StPick;
        end else begin
          tap_d   = tap_q + 6'd1;
          value_d = tap_q + 6'd1;
          state_d = StLoad;
        end
      end
      StPick: begin
        eye_start_d = best_start_q;
        eye_width_d = best_w_q;
        if (best_w_q < 7'(MIN_EYE)) begin
          state_d = StFail;
          fail_d  = 1'b1;
          code_d  = 2'b01;
        end else begin
          tap_d   = center_sum[5:0];
          value_d = center_sum[5:0];
          state_d = StCload;
        end
      end
      StCheck: begin
        if (hit_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (bitslip_count_o == 4'(MAX_BITSLIP)) begin
          state_d = StFail;
          fail_d  = 1'b1;
          code_d  = 2'b10;
        end else begin
          state_d = StSlip;
          slips_d = bitslip_count_o + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Strobes are registered from the next state so they line up with the state register.
    busy_d = !(state_d inside {StIdle, StDone, StFail});
    srst_d = (state_d == StSrst);
    load_d = (state_d inside {StLoad, StCload});
    slip_d = (state_d == StSlip);
    cap_d  = (state_d inside {StCapture, StCcapture});
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      tap_q             <= '0;
      run_start_q       <= '0;
      run_len_q         <= '0;
      best_start_q      <= '0;
      best_w_q          <= '0;
      hit_q             <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      fail_o            <= 1'b0;
      fail_code_o       <= '0;
      iserdes_rst_o     <= 1'b0;
      idelay_value_o    <= '0;
      idelay_load_o     <= 1'b0;
      iserdes_bitslip_o <= 1'b0;
      capture_o         <= 1'b0;
      eye_start_o       <= '0;
      eye_width_o       <= '0;
      bitslip_count_o   <= '0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      tap_q             <= tap_d;
      run_start_q       <= run_start_d;
      run_len_q         <= run_len_d;
      best_start_q      <= best_start_d;
      best_w_q          <= best_w_d;
      hit_q             <= hit_d;
      busy_o            <= busy_d;
      done_o            <= done_d;
      fail_o            <= fail_d;
      fail_code_o       <= code_d;
      iserdes_rst_o     <= srst_d;
      idelay_value_o    <= value_d;
      idelay_load_o     <= load_d;
      iserdes_bitslip_o <= slip_d;
      capture_o         <= cap_d;
      eye_start_o       <= eye_start_d;
      eye_width_o       <= eye_width_d;
      bitslip_count_o   <= slips_d;
    end
  end

`ifdef SURF_ALIGN_EYE_MAP_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) eye_map_o <= '0;
    else            eye_map_o <= map_d;
  end
`else
  assign eye_map_o = '0;
`endif

endmodule

// File: tb/tb_surf_cout_align_sequencer.sv
// Randomized bench for surf_cout_align_sequencer with a behavioural lane model and eye/slip reference.
module tb_surf_cout_align_sequencer;

  localparam logic [31:0] Train = 32'hA55A6996;
  localparam int MinEye = 4;
  localparam int MaxSlip = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, fail, iserdes_rst, idelay_load, bitslip, capture, capture_valid;
  logic [1:0]  fail_code;
  logic [5:0]  idelay_value, eye_start;
  logic [6:0]  eye_width;
  logic [3:0]  bitslip_count;
  logic [31:0] capture_data;
  logic [63:0] eye_map;

  int n_checks = 0;
  int n_fails  = 0;

  // Lane model state
  logic [63:0] lane_pass = '0;
  int          lane_rot = 0;
  bit          lane_slip_en = 1'b1;
  int          withhold_tap = -1;
  int          cur_tap = 0;
  int          pend = 0;

  surf_cout_align_sequencer dut (
    .wb_clk_i          (clk),
    .wb_rst_ni         (rst_n),
    .start_i           (start),
    .busy_o            (busy),
    .done_o            (done),
    .fail_o            (fail),
    .fail_code_o       (fail_code),
    .iserdes_rst_o     (iserdes_rst),
    .idelay_value_o    (idelay_value),
    .idelay_load_o     (idelay_load),
    .iserdes_bitslip_o (bitslip),
    .capture_o         (capture),
    .capture_valid_i   (capture_valid),
    .capture_data_i    (capture_data),
    .eye_start_o       (eye_start),
    .eye_width_o       (eye_width),
    .bitslip_count_o   (bitslip_count),
    .eye_map_o         (eye_map)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    int k;
    k = n % 32;
    if (k == 0) return v;
    return (v << k) | (v >> (32 - k));
  endfunction

  function automatic bit is_rot(input logic [31:0] d);
    for (int i = 0; i < 32; i++) if (d == rotl(Train, i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] garbage();
    logic [31:0] v;
    v = $urandom;
    while (is_rot(v)) v = $urandom;
    return v;
  endfunction

  // Longest run of passing taps, searched from every start; first found wins ties.
  task automatic find_eye(input logic [63:0] pass, output int bs, output int bw);
    bs = 0;
    bw = 0;
    for (int s = 0; s < 64; s++) begin
      int n;
      n = 0;
      while (s + n < 64 && pass[s + n]) n++;
      if (n > bw) begin
        bw = n;
        bs = s;
      end
    end
  endtask

  // Lane: latches tap on load, rotates on bitslip, answers captures after 1..4 cycles.
  initial begin
    capture_valid = 1'b0;
    capture_data  = '0;
    forever begin
      @(negedge clk);
      capture_valid = 1'b0;
      if (!rst_n) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          capture_valid = 1'b1;
          capture_data  = lane_pass[cur_tap] ? rotl(Train, lane_rot) : garbage();
        end
      end
      if (idelay_load) cur_tap = int'(idelay_value);
      if (bitslip && lane_slip_en) lane_rot = (lane_rot + 31) % 32;
      if (capture && cur_tap != withhold_tap) pend = $urandom_range(1, 4);
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (!busy && (done || fail)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_load(input int tap, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (idelay_load && int'(idelay_value) == tap) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_align(input string tag, input logic [63:0] pass, input int r0,
                           input bit slip_en);
    bit ok;
    int bs, bw, center, e_slips, e_value;
    bit e_done;
    logic [1:0] e_code;
    lane_pass    = pass;
    lane_rot     = r0;
    lane_slip_en = slip_en;
    withhold_tap = -1;
    pulse_start();
    wait_end(ok);
    check({tag, "_finished"}, 64'(ok), 64'd1);
    find_eye(pass, bs, bw);
    center = bs + bw / 2;
    if (bw < MinEye) begin
      e_done = 0; e_code = 2'b01; e_value = 63; e_slips = 0;
    end else if (slip_en ? (r0 <= MaxSlip) : (r0 % 32 == 0)) begin
      e_done = 1; e_code = 2'b00; e_value = center; e_slips = slip_en ? r0 : 0;
    end else begin
      e_done = 0; e_code = 2'b10; e_value = center; e_slips = MaxSlip;
    end
    check({tag, "_done"}, 64'(done), 64'(e_done));
    check({tag, "_fail"}, 64'(fail), 64'(!e_done));
    check({tag, "_code"}, 64'(fail_code), 64'(e_code));
    check({tag, "_eye_start"}, 64'(eye_start), 64'(bs));
    check({tag, "_eye_width"}, 64'(eye_width), 64'(bw));
    check({tag, "_idelay"}, 64'(idelay_value), 64'(e_value));
    check({tag, "_slips"}, 64'(bitslip_count), 64'(e_slips));
`ifdef SURF_ALIGN_EYE_MAP_EN
    check({tag, "_map"}, eye_map, pass);
`else
    check({tag, "_map"}, eye_map, 64'd0);
`endif
  endtask

  function automatic logic [63:0] range_mask(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  logic [31:0] outs;
  assign outs = {busy, done, fail, fail_code, iserdes_rst, idelay_value, idelay_load, bitslip,
                 capture, eye_start, eye_width, bitslip_count};

  initial begin
    bit ok;
    int cycles;
    logic [63:0] p;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(outs), 64'd0);
    check("reset_map", eye_map, 64'd0);
    rst_n = 1'b1;

    // Main lane: taps 20..35, rotated 3, aligns after 3 slips.
    run_align("main", range_mask(20, 35), 3, 1'b1);
    check("main_center_const", 64'(idelay_value), 64'd28);

    // Two equal eyes plus isolated edge taps that must not merge.
    p = range_mask(5, 12) | range_mask(40, 47);
    p[0] = 1'b1;
    p[63] = 1'b1;
    run_align("two_eyes", p, 0, 1'b1);
    check("two_eyes_center_const", 64'(idelay_value), 64'd9);

    run_align("narrow", range_mask(10, 12), 2, 1'b1);
    check("narrow_code_const", 64'(fail_code), 64'd1);

    run_align("nomatch", range_mask(20, 35), 5, 1'b0);
    check("nomatch_slips_const", 64'(bitslip_count), 64'd8);

    // Capture withheld at tap 7: timeout after CAPTURE_TIMEOUT wait cycles.
    lane_pass    = range_mask(3, 40);
    lane_rot     = 0;
    withhold_tap = 7;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (capture && int'(idelay_value) == 7) ok = 1'b1;
    end
    check("timeout_capture_seen", 64'(ok), 64'd1);
    cycles = 0;
    while (!fail && cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
    check("timeout_latency", 64'(cycles), 64'd256);
    check("timeout_code", 64'(fail_code), 64'd3);
    check("timeout_idelay", 64'(idelay_value), 64'd7);
    check("timeout_busy", 64'(busy), 64'd0);
    run_align("realign", range_mask(3, 40), 1, 1'b1);

    // Reset mid-SETTLE at tap 30.
    lane_pass = range_mask(20, 35);
    lane_rot  = 3;
    pulse_start();
    wait_load(30, ok);
    check("rst_reach_tap30", 64'(ok), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'(outs), 64'd0);
    check("midrst_map", eye_map, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_idle", 64'(outs), 64'd0);

    // start while busy must not restart the scan.
    pulse_start();
    wait_load(10, ok);
    check("busy_reach_tap10", 64'(ok), 64'd1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (idelay_load) ok = 1'b1;
    end
    check("busy_start_next_tap", 64'(idelay_value), 64'd11);
    wait_end(ok);
    check("busy_start_finished", 64'(done), 64'd1);

    // Random eyes and rotations.
    for (int t = 0; t < 5; t++) begin
      int s0, w0;
      s0 = $urandom_range(0, 63);
      w0 = $urandom_range(1, 24);
      p  = range_mask(s0, (s0 + w0 - 1 > 63) ? 63 : s0 + w0 - 1);
      if ($urandom_range(0, 1) == 1) begin
        s0 = $urandom_range(0, 63);
        w0 = $urandom_range(1, 24);
        p  = p | range_mask(s0, (s0 + w0 - 1 > 63) ? 63 : s0 + w0 - 1);
      end
      run_align($sformatf("rand%0d", t), p, $urandom_range(0, 10), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
